// File: rtl/vga_timing_gen.sv
// Raster timing generator for 640x480@60 Hz on the 25 MHz pixel clock.
// Counters (hc, vc) walk the full raster; every output is registered from
// them, so all outputs describe the same pixel one cycle after the counters.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic        clk_25MHz,
    input  logic        reset_al,
    input  logic        en,
    output logic        hsync,
    output logic        vsync,
    output logic        vde,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        frame_start,
    output logic        vblank_start,
    output logic [15:0] frame_count
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] HLast      = 10'(H_TOTAL - 1);
    localparam logic [9:0] VLast      = 10'(V_TOTAL - 1);
    localparam logic [9:0] HActive    = 10'(H_ACTIVE);
    localparam logic [9:0] VActive    = 10'(V_ACTIVE);
    localparam logic [9:0] HSyncStart = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HSyncEnd   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VSyncStart = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VSyncEnd   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]  hc_q, hc_d;
    logic [9:0]  vc_q, vc_d;
    logic        started_q;
    logic [9:0]  draw_x_q, draw_y_q;
    logic        hsync_q, vsync_q, vde_q;
    logic        frame_start_q, vblank_start_q;
    logic [15:0] frame_count_q;

    logic        vde_d, hsync_d, vsync_d;
    logic        at_origin, at_vblank;

    // Next raster position: hc wraps each line, vc wraps with the last line's hc wrap.
    always_comb begin
        hc_d = hc_q + 10'd1;
        vc_d = vc_q;
        if (hc_q == HLast) begin
            hc_d = 10'd0;
            vc_d = (vc_q == VLast) ? 10'd0 : vc_q + 10'd1;
        end
    end

    // Decode of the pixel the counters currently point at.
    always_comb begin
        vde_d     = (hc_q < HActive) && (vc_q < VActive);
        hsync_d   = ((hc_q >= HSyncStart) && (hc_q < HSyncEnd)) ? SYNC_POL : ~SYNC_POL;
        vsync_d   = ((vc_q >= VSyncStart) && (vc_q < VSyncEnd)) ? SYNC_POL : ~SYNC_POL;
        at_origin = (hc_q == 10'd0) && (vc_q == 10'd0);
        at_vblank = (hc_q == 10'd0) && (vc_q == VActive);
    end

    // Counter and output registers; reset wins over en, en=0 freezes levels and kills pulses.
    always_ff @(posedge clk_25MHz) begin
        if (!reset_al) begin
            hc_q           <= 10'd0;
            vc_q           <= 10'd0;
            started_q      <= 1'b0;
            draw_x_q       <= 10'd0;
            draw_y_q       <= 10'd0;
            vde_q          <= 1'b0;
            hsync_q        <= ~SYNC_POL;
            vsync_q        <= ~SYNC_POL;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
            frame_count_q  <= 16'd0;
        end else if (en) begin
            hc_q           <= hc_d;
            vc_q           <= vc_d;
            draw_x_q       <= hc_q;
            draw_y_q       <= vc_q;
            vde_q          <= vde_d;
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
            frame_start_q  <= at_origin;
            vblank_start_q <= at_vblank;
            if (at_origin) begin
                // The first frame after reset is frame 0; later frames count up.
                started_q <= 1'b1;
                if (started_q) begin
                    frame_count_q <= frame_count_q + 16'd1;
                end
            end
        end else begin
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
        end
    end

    assign DrawX        = draw_x_q;
    assign DrawY        = draw_y_q;
    assign vde          = vde_q;
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign frame_start  = frame_start_q;
    assign vblank_start = vblank_start_q;
    assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen using a reduced raster geometry so
// whole frames fit in a short run. Reference model tracks a linear pixel index.
module tb_vga_timing_gen;

    localparam int  HA = 16, HF = 4, HS = 6, HB = 4;
    localparam int  VA = 12, VF = 2, VS = 2, VB = 3;
    localparam int  HT = HA + HF + HS + HB;
    localparam int  VT = VA + VF + VS + VB;
    localparam int  FRAME = HT * VT;
    localparam bit  POL = 1'b0;

    logic        clk = 1'b0;
    logic        reset_al = 1'b0;
    logic        en = 1'b0;
    logic        hsync, vsync, vde, frame_start, vblank_start;
    logic [9:0]  DrawX, DrawY;
    logic [15:0] frame_count;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(POL)
    ) dut (
        .clk_25MHz   (clk),
        .reset_al    (reset_al),
        .en          (en),
        .hsync       (hsync),
        .vsync       (vsync),
        .vde         (vde),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .frame_start (frame_start),
        .vblank_start(vblank_start),
        .frame_count (frame_count)
    );

    always #20 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: m_p is the linear index of the next pixel to be shown.
    int          m_p = 0;
    bit          m_started = 1'b0;
    logic [9:0]  e_x = '0, e_y = '0;
    logic        e_vde = 1'b0, e_hs = ~POL, e_vs = ~POL, e_fs = 1'b0, e_vb = 1'b0;
    logic [15:0] e_fc = '0;

    task automatic check1(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst_n, input logic e);
        int x, y;
        if (!rst_n) begin
            m_p = 0; m_started = 1'b0;
            e_x = '0; e_y = '0; e_vde = 1'b0; e_hs = ~POL; e_vs = ~POL;
            e_fs = 1'b0; e_vb = 1'b0; e_fc = '0;
        end else if (e) begin
            x = m_p % HT;
            y = m_p / HT;
            e_x   = 10'(x);
            e_y   = 10'(y);
            e_vde = (x < HA) && (y < VA);
            e_hs  = (x >= HA + HF && x < HA + HF + HS) ? POL : ~POL;
            e_vs  = (y >= VA + VF && y < VA + VF + VS) ? POL : ~POL;
            e_fs  = (m_p == 0);
            e_vb  = (m_p == VA * HT);
            if (m_p == 0) begin
                if (m_started) e_fc = e_fc + 16'd1;
                m_started = 1'b1;
            end
            m_p = (m_p + 1) % FRAME;
        end else begin
            e_fs = 1'b0;
            e_vb = 1'b0;
        end
    endtask

    // One clock edge with the given inputs, then compare every output with the model.
    task automatic step(input logic rst_n, input logic e);
        reset_al = rst_n;
        en       = e;
        @(posedge clk);
        #1;
        model_edge(rst_n, e);
        check1("DrawX", 16'(DrawX), 16'(e_x));
        check1("DrawY", 16'(DrawY), 16'(e_y));
        check1("vde", 16'(vde), 16'(e_vde));
        check1("hsync", 16'(hsync), 16'(e_hs));
        check1("vsync", 16'(vsync), 16'(e_vs));
        check1("frame_start", 16'(frame_start), 16'(e_fs));
        check1("vblank_start", 16'(vblank_start), 16'(e_vb));
        check1("frame_count", frame_count, e_fc);
    endtask

    // Advance with en=1 until the model shows (tx,ty); an expired budget counts as a failure.
    task automatic run_until(input int tx, input int ty, input int limit, input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < limit && !hit; i++) begin
            step(1'b1, 1'b1);
            if (int'(e_x) == tx && int'(e_y) == ty) hit = 1'b1;
        end
        n_cmp++;
        assert (hit) else begin
            n_bad++;
            $error("FAIL %s: position (%0d,%0d) not reached within %0d cycles", tag, tx, ty,
                   limit);
        end
    endtask

    int hs_low, vs_low, fs_cnt, vb_cnt;

    initial begin
        // Reset held with en=1.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
        check1("rst_hsync", 16'(hsync), 16'd1);
        check1("rst_vsync", 16'(vsync), 16'd1);

        // First full frame after release, counting sync widths and pulses.
        hs_low = 0; vs_low = 0; fs_cnt = 0; vb_cnt = 0;
        for (int n = 1; n <= FRAME; n++) begin
            step(1'b1, 1'b1);
            if (n == 1) begin
                check1("edge1_vde", 16'(vde), 16'd1);
                check1("edge1_fs", 16'(frame_start), 16'd1);
            end
            if (n == HA + 1) check1("edge_ha_vde", 16'(vde), 16'd0);
            if (n == HT + 1) check1("line1_y", 16'(DrawY), 16'd1);
            if (n <= HT && hsync == 1'b0) hs_low++;
            if (vsync == 1'b0) vs_low++;
            if (frame_start) fs_cnt++;
            if (vblank_start) vb_cnt++;
        end
        check1("hsync_width", 16'(hs_low), 16'(HS));
        check1("vsync_width", 16'(vs_low), 16'(VS * HT));
        check1("fs_pulses", 16'(fs_cnt), 16'd1);
        check1("vb_pulses", 16'(vb_cnt), 16'd1);
        step(1'b1, 1'b1);
        check1("frame1_fs", 16'(frame_start), 16'd1);
        check1("frame1_count", frame_count, 16'd1);

        // Enable hold at (HA-1, 10).
        run_until(HA - 1, 10, 2 * FRAME, "reach_hold");
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        check1("hold_x", 16'(DrawX), 16'(HA - 1));
        step(1'b1, 1'b1);
        check1("resume_x", 16'(DrawX), 16'(HA));
        check1("resume_vde", 16'(vde), 16'd0);

        // Random enable pattern across several frames.
        for (int i = 0; i < 3 * FRAME; i++) step(1'b1, ($urandom_range(0, 3) != 0));

        // Mid-frame reset.
        run_until(HA + HF + 2, 8, 2 * FRAME, "reach_midreset");
        step(1'b0, 1'b1);
        check1("midrst_x", 16'(DrawX), 16'd0);
        step(1'b1, 1'b1);
        check1("midrst_fs", 16'(frame_start), 16'd1);
        check1("midrst_fc", frame_count, 16'd0);

        // frame_count wrap: preload 16'hFFFF while frozen, then finish the frame.
        run_until(HT - 3, VT - 1, 2 * FRAME, "reach_wrap");
        step(1'b1, 1'b0);
        force dut.frame_count_q = 16'hFFFF;
        e_fc = 16'hFFFF;
        step(1'b1, 1'b0);
        release dut.frame_count_q;
        step(1'b1, 1'b0);
        run_until(0, 0, FRAME, "reach_wrap_origin");
        check1("wrap_fs", 16'(frame_start), 16'd1);
        check1("wrap_fc", frame_count, 16'd0);
        step(1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
